pipelined_right_shifter: RTL

- Pipelined right barrel shifter. Complements the existing left-shift stage chain and supplies the right-shift direction for the barrel-shifter datapath.
- Shifts a WIDTH-bit word right by 0..WIDTH-1 positions in one of three modes: logical, arithmetic or rotate.
- Built as log2(WIDTH) registered stages, shifting by 1, 2, 4, 8, ... in that order.
- valid/ready handshake on input and output; accepts one word per cycle when not back-pressured.

---
 rtl/shifter_pkg.sv | 12 +
 rtl/shift_right_stage.sv | 59 +++++
 rtl/pipelined_right_shifter.sv | 69 ++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel-shifter datapath: shift modes and default width.
package shifter_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LSR = 2'b00;
  localparam mode_t MODE_ASR = 2'b01;
  localparam mode_t MODE_ROR = 2'b10;

endpackage

// File: rtl/shift_right_stage.sv
// One pipeline slot of the right shifter: conditional shift by DIST with mode fill,
// followed by a registered slot with bubble-collapsing valid/ready.
module shift_right_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic             vld_i,
  output logic             rdy_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  mode_t            mode_i,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output mode_t            mode_o
);

  logic [DIST-1:0]  fill;
  logic [WIDTH-1:0] shifted;

  // Arithmetic fill copies the stage-input MSB; earlier stages have already
  // replicated the original sign there, so this stays correct down the chain.
  always_comb begin
    fill = '0;
    case (mode_i)
      MODE_ASR: fill = {DIST{data_i[WIDTH-1]}};
      MODE_ROR: fill = data_i[DIST-1:0];
      default:  fill = '0;
    endcase
    shifted = sel_i ? {fill, data_i[WIDTH-1:DIST]} : data_i;
  end

  // Slot may load when empty or when its current word leaves this cycle.
  assign rdy_o = !vld_o || rdy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o   <= 1'b0;
      data_o  <= '0;
      shamt_o <= '0;
      mode_o  <= MODE_LSR;
    end else if (rdy_o) begin
      vld_o <= vld_i;
      if (vld_i) begin
        data_o  <= shifted;
        shamt_o <= shamt_i;
        mode_o  <= mode_i;
      end
    end
  end

endmodule

// File: rtl/pipelined_right_shifter.sv
// Pipelined right barrel shifter: STAGES registered slots shifting by 1, 2, 4, ...
// Logical, arithmetic and rotate modes; valid/ready on both ends.
module pipelined_right_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SHW    = $clog2(WIDTH),
  parameter int STAGES = SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  mode_t            in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_right_shifter: WIDTH must be a power of 2 and >= 2");
  end

  // Index 0 is the input port; index k+1 is the output register of stage k.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic [STAGES:0][SHW-1:0]   shamt_pipe;
  mode_t [STAGES:0]           mode_pipe;

  assign vld_pipe[0]   = in_valid;
  assign data_pipe[0]  = in_data;
  assign shamt_pipe[0] = in_shamt;
  assign mode_pipe[0]  = in_mode;

  assign rdy_pipe[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_right_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .sel_i   (shamt_pipe[k][k]),
      .vld_i   (vld_pipe[k]),
      .rdy_o   (rdy_pipe[k]),
      .data_i  (data_pipe[k]),
      .shamt_i (shamt_pipe[k]),
      .mode_i  (mode_pipe[k]),
      .vld_o   (vld_pipe[k+1]),
      .rdy_i   (rdy_pipe[k+1]),
      .data_o  (data_pipe[k+1]),
      .shamt_o (shamt_pipe[k+1]),
      .mode_o  (mode_pipe[k+1])
    );
  end

  // Ready chain is built only from slot valids and out_ready, never in_valid.
  assign in_ready  = rdy_pipe[0];
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];
  assign busy      = |vld_pipe[STAGES:1];

endmodule
